// File: rtl/afifo_wr_arb.sv
// Round-robin write arbiter: grants one of NREQ packet sources the single afifo
// push port for a whole packet, with a beat limit that forces release.
module afifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DW       = 24,
  parameter int MAXBEATS = 64
) (
  input  logic                      wclk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_rdy,
  output logic                      push,
  output logic [DW-1:0]             data_in,
  input  logic                      full,
  input  logic                      alFull,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic                      err_maxbeat
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_gnt_id;
  logic [IW-1:0]   r_last_gnt;
  logic [7:0]      r_beat_cnt;
  logic            r_err_maxbeat;

  logic [IW-1:0]   w_sel;
  logic            w_any;
  int              w_idx;
  logic [NREQ-1:0] w_rdy;
  logic            w_push;
  logic            w_last;
  logic            w_force;
  logic            w_grant_start;
  logic [DW-1:0]   w_data;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    w_sel = r_last_gnt;
    w_any = 1'b0;
    w_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_last_gnt) + k) % NREQ;
      if (!w_any && req_vld[w_idx]) begin
        w_sel = IW'(w_idx);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdy  = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rdy[i] = (r_state == ST_GRANT) && (r_gnt_id == IW'(i)) && !full;
      if (r_gnt_id == IW'(i)) w_data = req_data[i*DW +: DW];
    end
  end

  // Only the granted bit of w_rdy can be set, so the reductions pick that lane.
  assign w_push        = |(req_vld & w_rdy);
  assign w_last        = |(req_vld & req_last & w_rdy);
  assign w_force       = w_push && !w_last && (r_beat_cnt == 8'(MAXBEATS-1));
  assign w_grant_start = (r_state == ST_IDLE) && w_any && !alFull;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_start) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_push && (w_last || w_force)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_id      <= '0;
      r_last_gnt    <= IW'(NREQ-1);
      r_beat_cnt    <= '0;
      r_err_maxbeat <= 1'b0;
    end else begin
      r_err_maxbeat <= w_force;
      if (w_grant_start) begin
        r_gnt_id   <= w_sel;
        r_beat_cnt <= '0;
      end else if (w_push) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (w_last || w_force) r_last_gnt <= r_gnt_id;
      end
    end
  end

  assign req_rdy     = w_rdy;
  assign push        = w_push;
  assign data_in     = w_data;
  assign gnt_id      = r_gnt_id;
  assign busy        = (r_state == ST_GRANT);
  assign err_maxbeat = r_err_maxbeat;

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: default instance plus a MAXBEATS=4 instance
// sharing the same stimulus for the forced-release case.
module tb_afifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 24;

  logic               wclk;
  logic               rst_n;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic               full;
  logic               alFull;

  logic [NREQ-1:0]    req_rdy,  m_req_rdy;
  logic               push,     m_push;
  logic [DW-1:0]      data_in,  m_data_in;
  logic [1:0]         gnt_id,   m_gnt_id;
  logic               busy,     m_busy;
  logic               err_maxbeat, m_err_maxbeat;

  int total = 0;
  int bad   = 0;
  int b;

  afifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAXBEATS(64)) dut (
    .wclk(wclk), .rst_n(rst_n), .req_vld(req_vld), .req_last(req_last),
    .req_data(req_data), .req_rdy(req_rdy), .push(push), .data_in(data_in),
    .full(full), .alFull(alFull), .gnt_id(gnt_id), .busy(busy),
    .err_maxbeat(err_maxbeat)
  );

  afifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAXBEATS(4)) dut_m (
    .wclk(wclk), .rst_n(rst_n), .req_vld(req_vld), .req_last(req_last),
    .req_data(req_data), .req_rdy(m_req_rdy), .push(m_push), .data_in(m_data_in),
    .full(full), .alFull(alFull), .gnt_id(m_gnt_id), .busy(m_busy),
    .err_maxbeat(m_err_maxbeat)
  );

  // Clock and watchdog
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] d);
    req_data = '0;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    full     = 1'b0;
    alFull   = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values, with all requesters valid during reset
    rst_n    = 1'b0;
    req_vld  = 4'hF;
    req_last = 4'hF;
    req_data = '0;
    full     = 1'b0;
    alFull   = 1'b0;
    cyc();
    cyc();
    chk("rst_push",  push, 0);
    chk("rst_rdy",   req_rdy, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_gnt",   gnt_id, 0);
    chk("rst_err",   err_maxbeat, 0);
    req_vld  = '0;
    req_last = '0;
    rst_n    = 1'b1;

    // Single 3-beat packet from requester 2
    req_vld = 4'b0100;
    set_lane(2, 24'hA);
    #1;
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_push", push, 0);
    cyc();
    #1;
    chk("sp_gnt",   gnt_id, 2);
    chk("sp_busy",  busy, 1);
    chk("sp_rdy",   req_rdy, 4'b0100);
    chk("sp_push0", push, 1);
    chk("sp_dat0",  data_in, 24'hA);
    cyc();
    set_lane(2, 24'hB);
    #1;
    chk("sp_push1", push, 1);
    chk("sp_dat1",  data_in, 24'hB);
    cyc();
    set_lane(2, 24'hC);
    req_last = 4'b0100;
    #1;
    chk("sp_push2", push, 1);
    chk("sp_dat2",  data_in, 24'hC);
    cyc();
    req_vld  = '0;
    req_last = '0;
    #1;
    chk("sp_busy_end", busy, 0);
    chk("sp_push_end", push, 0);
    chk("sp_gnt_hold", gnt_id, 2);

    // Round-robin with single-beat packets from all four
    do_reset();
    req_vld  = 4'hF;
    req_last = 4'hF;
    #1;
    chk("rr_idle_push", push, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk("rr_gnt",  gnt_id, k % 4);
      chk("rr_push", push, 1);
      cyc();
      #1;
      chk("rr_gap_push", push, 0);
      chk("rr_gap_busy", busy, 0);
    end
    req_vld  = '0;
    req_last = '0;

    // Backpressure: requester 1, 5 beats, full on packet cycles 2-4
    req_vld = 4'b0010;
    set_lane(1, 24'h11);
    cyc();
    #1;
    chk("bp_gnt", gnt_id, 1);
    b = 0;
    for (int c = 0; c < 8; c++) begin
      full = (c >= 1 && c <= 3);
      set_lane(1, 24'h11 + 24'(b));
      req_last = (b == 4) ? 4'b0010 : 4'b0000;
      #1;
      chk("bp_push", push, !full);
      chk("bp_rdy",  req_rdy, full ? 4'b0000 : 4'b0010);
      if (!full) begin
        chk("bp_data", data_in, 24'h11 + 24'(b));
        b++;
      end
      cyc();
    end
    req_vld  = '0;
    req_last = '0;
    full     = 1'b0;
    #1;
    chk("bp_busy_end", busy, 0);

    // alFull gating in IDLE, ignored mid-packet
    alFull  = 1'b1;
    req_vld = 4'b0010;
    set_lane(1, 24'h21);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("af_hold_busy", busy, 0);
      chk("af_hold_push", push, 0);
      cyc();
    end
    alFull = 1'b0;
    cyc();
    #1;
    chk("af_gnt",   gnt_id, 1);
    chk("af_push0", push, 1);
    chk("af_dat0",  data_in, 24'h21);
    cyc();
    alFull = 1'b1;
    set_lane(1, 24'h22);
    #1;
    chk("af_push1", push, 1);
    chk("af_dat1",  data_in, 24'h22);
    cyc();
    set_lane(1, 24'h23);
    req_last = 4'b0010;
    #1;
    chk("af_push2", push, 1);
    cyc();
    #1;
    chk("af_busy_end", busy, 0);
    req_vld  = '0;
    req_last = '0;
    alFull   = 1'b0;

    // Forced release on the MAXBEATS=4 instance
    do_reset();
    req_vld = 4'b0011;
    set_lane(0, 24'h40);
    cyc();
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("mb_push", m_push, 1);
      chk("mb_gnt",  m_gnt_id, 0);
      chk("mb_err",  m_err_maxbeat, 0);
      cyc();
    end
    #1;
    chk("mb_rel_busy", m_busy, 0);
    chk("mb_rel_err",  m_err_maxbeat, 1);
    chk("mb_rel_push", m_push, 0);
    cyc();
    #1;
    chk("mb_err_clr",  m_err_maxbeat, 0);
    chk("mb_next_gnt", m_gnt_id, 1);
    chk("mb_next_busy", m_busy, 1);
    req_vld = '0;

    // Reset mid-packet after 2 of 4 beats
    do_reset();
    req_vld = 4'b0100;
    set_lane(2, 24'h31);
    cyc();
    #1;
    chk("rm_push0", push, 1);
    cyc();
    set_lane(2, 24'h32);
    #1;
    chk("rm_push1", push, 1);
    cyc();
    set_lane(2, 24'h33);
    rst_n = 1'b0;
    #1;
    chk("rm_push_rst", push, 0);
    chk("rm_rdy_rst",  req_rdy, 0);
    chk("rm_busy_rst", busy, 0);
    req_vld = 4'b1001;
    cyc();
    #1;
    chk("rm_push_hold", push, 0);
    chk("rm_gnt_rst",   gnt_id, 0);
    rst_n = 1'b1;
    #1;
    chk("rm_busy_rel", busy, 0);
    cyc();
    #1;
    chk("rm_gnt",  gnt_id, 0);
    chk("rm_busy", busy, 1);
    chk("rm_push", push, 1);
    req_vld = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
